// File: rtl/iq_gen_deadlock_pkg.sv
// Shared types and beat-format constants for the HLS deadlock reporter.
package iq_gen_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        REPORT,
        HOLD
    } state_t;

    localparam int MALFORMED_BIT = 7;
    localparam int CHAN_LSB      = 0;
    localparam int CHAN_W        = 4;

    localparam logic [7:0] UNATTRIB_BEAT = 8'hFF;
    localparam int         TS_BEATS      = 4;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] mask);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) lowest_set = 4'(i);
        end
    endfunction

    function automatic logic [7:0] chan_beat(input logic malformed, input logic [3:0] chan);
        chan_beat = '0;
        chan_beat[MALFORMED_BIT] = malformed;
        chan_beat[CHAN_LSB +: CHAN_W] = chan;
    endfunction

endpackage

// File: rtl/iq_gen_hls_deadlock_reporter_if.sv
// AXI-Stream style report channel carried from the deadlock reporter to its consumer.
interface iq_gen_hls_deadlock_reporter_if;
    logic [7:0] rpt_tdata;
    logic       rpt_tvalid;
    logic       rpt_tready;
    logic       rpt_tlast;

    modport master (
        output rpt_tdata,
        output rpt_tvalid,
        output rpt_tlast,
        input  rpt_tready
    );

    modport slave (
        input  rpt_tdata,
        input  rpt_tvalid,
        input  rpt_tlast,
        output rpt_tready
    );
endinterface

// File: rtl/iq_gen_deadlock_nibble_decode.sv
// Combinational decode of the frozen block-info snapshot into per-channel flags.
module iq_gen_deadlock_nibble_decode #(
    parameter int NUM_AXIS = 4
) (
    input  logic [4*NUM_AXIS-1:0] snapshot,
    output logic [NUM_AXIS-1:0]   reported,
    output logic [NUM_AXIS-1:0]   malformed
);

    generate
        for (genvar gi = 0; gi < NUM_AXIS; gi++) begin : g_chan
            // A well-formed blocked nibble is one-cold at bit (channel mod 4).
            localparam logic [3:0] ONE_COLD = ~(4'h1 << (gi % 4));
            logic [3:0] nib;
            assign nib            = snapshot[4*gi +: 4];
            assign reported[gi]   = (nib != 4'h0);
            assign malformed[gi]  = (nib != 4'h0) && (nib != ONE_COLD);
        end
    endgenerate

endmodule

// File: rtl/iq_gen_hls_deadlock_reporter.sv
// Qualifies a persistent monitor block and streams one report beat per blocked channel.
// Define DEADLOCK_RPT_TIMESTAMP_EN to append a 4-beat capture timestamp to each report.
module iq_gen_hls_deadlock_reporter
    import iq_gen_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 4,
    parameter int THRESH_W = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          block,
    input  logic [4*NUM_AXIS-1:0]         axis_block_info,
    input  logic [THRESH_W-1:0]           threshold,
    input  logic                          clear,
    iq_gen_hls_deadlock_reporter_if.master rpt,
    output logic                          deadlock
);

`ifdef DEADLOCK_RPT_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
    logic [31:0] ts_ctr_reg, ts_cap_reg, ts_cap_next;
    logic [2:0]  ts_idx_reg, ts_idx_next;
`else
    localparam bit TS_EN = 1'b0;
`endif

    state_t                 state_reg, state_next;
    logic [THRESH_W-1:0]    cnt_reg, cnt_next, thr_eff;
    logic [4*NUM_AXIS-1:0]  snap_reg, snap_next;
    logic [NUM_AXIS-1:0]    pend_reg, pend_next, rep_vec, mal_vec, src_mask, pend_after;
    logic [7:0]             tdata_reg, tdata_next, ch_beat;
    logic                   tvalid_reg, tvalid_next, tlast_reg, tlast_next;
    logic                   dead_reg, dead_next, ch_final;
    logic [3:0]             ch_idx;
    logic [15:0]            mal_ext;

    iq_gen_deadlock_nibble_decode #(.NUM_AXIS(NUM_AXIS)) u_decode (
        .snapshot  (snap_reg),
        .reported  (rep_vec),
        .malformed (mal_vec)
    );

    assign thr_eff = (threshold == '0) ? THRESH_W'(1) : threshold;

    // First beat scans the whole snapshot; later beats scan what is still pending.
    assign src_mask = tvalid_reg ? pend_reg : rep_vec;
    assign ch_idx   = lowest_set(16'(src_mask));
    assign mal_ext  = 16'(mal_vec);
    assign ch_beat  = chan_beat(mal_ext[ch_idx], ch_idx);
    assign ch_final = (pend_after == '0) && !TS_EN;

    generate
        for (genvar gi = 0; gi < NUM_AXIS; gi++) begin : g_pend
            assign pend_after[gi] = src_mask[gi] && (ch_idx != 4'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        snap_next   = snap_reg;
        pend_next   = pend_reg;
        tdata_next  = tdata_reg;
        tvalid_next = tvalid_reg;
        tlast_next  = tlast_reg;
        dead_next   = dead_reg;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
        ts_cap_next = ts_cap_reg;
        ts_idx_next = ts_idx_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (block) begin
                    state_next = QUAL;
                    cnt_next   = THRESH_W'(1);
                end
            end
            QUAL: begin
                if (cnt_reg >= thr_eff) begin
                    snap_next  = axis_block_info;
                    state_next = REPORT;
                    cnt_next   = '0;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
                    ts_cap_next = ts_ctr_reg;
`endif
                end else if (block) begin
                    if (cnt_reg != '1) cnt_next = cnt_reg + THRESH_W'(1);
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            REPORT: begin
                if (!tvalid_reg) begin
                    tvalid_next = 1'b1;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
                    ts_idx_next = '0;
`endif
                    if (rep_vec == '0) begin
                        tdata_next = UNATTRIB_BEAT;
                        pend_next  = '0;
                        tlast_next = !TS_EN;
                    end else begin
                        tdata_next = ch_beat;
                        pend_next  = pend_after;
                        tlast_next = ch_final;
                    end
                end else if (rpt.rpt_tready) begin
                    if (tlast_reg) begin
                        tvalid_next = 1'b0;
                        tlast_next  = 1'b0;
                        tdata_next  = '0;
                        dead_next   = 1'b1;
                        state_next  = HOLD;
                    end
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
                    else if (pend_reg == '0) begin
                        tdata_next  = ts_cap_reg[{ts_idx_reg[1:0], 3'b000} +: 8];
                        tlast_next  = (ts_idx_reg == 3'(TS_BEATS - 1));
                        ts_idx_next = ts_idx_reg + 3'd1;
                    end
`endif
                    else begin
                        tdata_next = ch_beat;
                        pend_next  = pend_after;
                        tlast_next = ch_final;
                    end
                end
            end
            HOLD: begin
                if (clear) begin
                    state_next = IDLE;
                    dead_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            snap_reg   <= '0;
            pend_reg   <= '0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
            dead_reg   <= 1'b0;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
            ts_ctr_reg <= '0;
            ts_cap_reg <= '0;
            ts_idx_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            snap_reg   <= snap_next;
            pend_reg   <= pend_next;
            tdata_reg  <= tdata_next;
            tvalid_reg <= tvalid_next;
            tlast_reg  <= tlast_next;
            dead_reg   <= dead_next;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
            ts_ctr_reg <= ts_ctr_reg + 32'd1;
            ts_cap_reg <= ts_cap_next;
            ts_idx_reg <= ts_idx_next;
`endif
        end
    end

    assign rpt.rpt_tdata  = tdata_reg;
    assign rpt.rpt_tvalid = tvalid_reg;
    assign rpt.rpt_tlast  = tlast_reg;
    assign deadlock       = dead_reg;

endmodule

// File: tb/tb_iq_gen_hls_deadlock_reporter.sv
// Directed plus randomized bench for the deadlock reporter, checked against a packet-level model.
`timescale 1ns/1ps
module tb_iq_gen_hls_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        block = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] info = '0;
    logic [15:0] threshold = '0;
    logic        deadlock;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
    logic [31:0] tsm;
    logic [31:0] exp_ts;
`endif

    iq_gen_hls_deadlock_reporter_if rpt_if();

    iq_gen_hls_deadlock_reporter #(.NUM_AXIS(4), .THRESH_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_info (info),
        .threshold       (threshold),
        .clear           (clear),
        .rpt             (rpt_if),
        .deadlock        (deadlock)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
    always @(posedge clock or negedge reset)
        if (!reset) tsm <= '0;
        else        tsm <= tsm + 32'd1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected packet: ascending blocked channels, malformed flagged in bit 7, FF if none.
    function automatic void build_expected(input logic [15:0] inf);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] nib;
            logic [3:0] one_hot;
            nib = inf[4*i +: 4];
            one_hot = 4'b0001 << i;
            if (nib != 4'h0)
                exp_q.push_back((nib == ~one_hot) ? 8'(i) : (8'h80 | 8'(i)));
        end
        if (exp_q.size() == 0) exp_q.push_back(8'hFF);
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
        for (int b = 0; b < 4; b++) exp_q.push_back(exp_ts[8*b +: 8]);
`endif
    endfunction

    // Hold block just long enough to qualify; no beat may appear before that.
    task automatic start(input logic [15:0] inf, input logic [15:0] thr);
        int eff;
        eff = (thr == 16'd0) ? 1 : int'(thr);
        info = inf;
        threshold = thr;
        block = 1'b1;
        for (int k = 0; k < eff; k++) begin
            clear = 1'($urandom_range(0, 1));
            tick();
            check("no_early_report", 32'(rpt_if.rpt_tvalid), 32'd0);
        end
`ifdef DEADLOCK_RPT_TIMESTAMP_EN
        exp_ts = tsm;
`endif
        block = 1'($urandom_range(0, 1));
    endtask

    // mode 0: tready always high, 1: toggling with clear held high, 2: random tready
    task automatic collect(input int mode);
        int idx;
        int budget;
        int last_cyc;
        bit stalled;
        bit rdy;
        bit tog;
        logic [7:0] hd;
        logic hl;
        idx = 0; budget = 0; last_cyc = -1; stalled = 0; tog = 0; hd = '0; hl = 1'b0;
        build_expected(info);
        while (idx < exp_q.size() && budget < 300) begin
            if (stalled) begin
                check("stall_tvalid", 32'(rpt_if.rpt_tvalid), 32'd1);
                check("stall_tdata", 32'(rpt_if.rpt_tdata), 32'(hd));
                check("stall_tlast", 32'(rpt_if.rpt_tlast), 32'(hl));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = !tog; end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rpt_if.rpt_tready = rdy;
            stalled = 0;
            if (rpt_if.rpt_tvalid) begin
                check("deadlock_during_report", 32'(deadlock), 32'd0);
                if (rdy) begin
                    check("beat_data", 32'(rpt_if.rpt_tdata), 32'(exp_q[idx]));
                    check("beat_last", 32'(rpt_if.rpt_tlast), 32'(idx == exp_q.size() - 1));
                    if (mode == 0 && last_cyc >= 0)
                        check("back_to_back", 32'(cyc - last_cyc), 32'd1);
                    $display("beat %0d: tdata=%02h tlast=%0b expected %02h", idx,
                             rpt_if.rpt_tdata, rpt_if.rpt_tlast, exp_q[idx]);
                    last_cyc = cyc;
                    idx++;
                end else begin
                    stalled = 1;
                    hd = rpt_if.rpt_tdata;
                    hl = rpt_if.rpt_tlast;
                end
            end
            block = 1'($urandom_range(0, 1));
            clear = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        check("packet_complete", 32'(idx), 32'(exp_q.size()));
        clear = 1'b0;
        rpt_if.rpt_tready = 1'b0;
        check("tvalid_after_packet", 32'(rpt_if.rpt_tvalid), 32'd0);
        check("deadlock_set", 32'(deadlock), 32'd1);
    endtask

    task automatic release_hold();
        for (int k = 0; k < 2; k++) begin
            block = 1'b1;
            tick();
            check("hold_ignores_block", 32'(rpt_if.rpt_tvalid), 32'd0);
            check("hold_sticky", 32'(deadlock), 32'd1);
        end
        block = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_releases", 32'(deadlock), 32'd0);
        tick();
        check("idle_after_clear", 32'(rpt_if.rpt_tvalid), 32'd0);
    endtask

    initial begin
        logic [15:0] ri;
        logic [3:0]  nib;
        bit          seen;
        rpt_if.rpt_tready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_tvalid", 32'(rpt_if.rpt_tvalid), 32'd0);
        check("reset_tlast", 32'(rpt_if.rpt_tlast), 32'd0);
        check("reset_tdata", 32'(rpt_if.rpt_tdata), 32'd0);
        check("reset_deadlock", 32'(deadlock), 32'd0);
        reset = 1'b1;
        tick();

        // Single well-formed channel, all four channels, malformed, unattributed
        start(16'h000E, 16'd3); collect(0); release_hold();
        start(16'h7BDE, 16'd3); collect(0); release_hold();
        start(16'h0F00, 16'd1); collect(0); release_hold();
        start(16'h0000, 16'd0); collect(2); release_hold();
        // Back-pressure every other cycle, clear held high throughout the report
        start(16'h7BDE, 16'd2); collect(1); release_hold();

        // Interrupted run must restart qualification
        threshold = 16'd5;
        info = 16'h7BDE;
        block = 1'b1;
        repeat (4) begin
            tick();
            check("broken_run_quiet", 32'(rpt_if.rpt_tvalid), 32'd0);
        end
        block = 1'b0;
        tick();
        check("gap_quiet", 32'(rpt_if.rpt_tvalid), 32'd0);
        start(16'h7BDE, 16'd5); collect(0); release_hold();

        // Run shorter than threshold never reports
        threshold = 16'd4;
        block = 1'b1;
        repeat (3) tick();
        block = 1'b0;
        repeat (5) begin
            tick();
            check("short_run_quiet", 32'(rpt_if.rpt_tvalid), 32'd0);
            check("short_run_no_deadlock", 32'(deadlock), 32'd0);
        end

        for (int n = 0; n < 25; n++) begin
            ri = '0;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       nib = 4'h0;
                    1, 2:    nib = ~(4'b0001 << i);
                    default: nib = 4'($urandom_range(1, 15));
                endcase
                ri[4*i +: 4] = nib;
            end
            start(ri, 16'($urandom_range(0, 4)));
            collect(int'($urandom_range(0, 2)));
            release_hold();
        end

        // Reset while holding the sticky flag
        start(16'h7BDE, 16'd1); collect(0);
        reset = 1'b0;
        #1;
        check("async_reset_deadlock", 32'(deadlock), 32'd0);
        check("async_reset_tvalid_hold", 32'(rpt_if.rpt_tvalid), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Reset mid-packet
        start(16'h7BDE, 16'd2);
        rpt_if.rpt_tready = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = rpt_if.rpt_tvalid;
        end
        check("midpkt_tvalid_seen", 32'(seen), 32'd1);
        rpt_if.rpt_tready = 1'b1;
        tick();
        rpt_if.rpt_tready = 1'b0;
        check("midpkt_second_beat", 32'(rpt_if.rpt_tdata), 32'h01);
        reset = 1'b0;
        #1;
        check("midpkt_reset_tvalid", 32'(rpt_if.rpt_tvalid), 32'd0);
        check("midpkt_reset_tlast", 32'(rpt_if.rpt_tlast), 32'd0);
        check("midpkt_reset_tdata", 32'(rpt_if.rpt_tdata), 32'd0);
        check("midpkt_reset_deadlock", 32'(deadlock), 32'd0);
        block = 1'b0;
        repeat (2) tick();
        check("in_reset_quiet", 32'(rpt_if.rpt_tvalid), 32'd0);
        reset = 1'b1;
        tick();
        check("after_reset_quiet", 32'(rpt_if.rpt_tvalid), 32'd0);
        start(16'h000E, 16'd3); collect(0); release_hold();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
